if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch front end that produces the IF-side inputs of the IF/ID pipeline register: instruction word, fetch PC+4 and flush strobe. Drives the instruction memory through a req/ready handshake and decouples memory latency with a 2-entry fetch buffer. Obeys the downstream write-enable (stall) and accepts PC redirects from branch/jump resolution, flushing in-flight work.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
AW, 32, PC/address width; PC arithmetic is modulo 2^AW.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request valid.
imem_addr  out  AW  fetch address, word-aligned.
imem_ready  in  1  memory accepts the request and returns data in the same cycle.
imem_rdata  in  32  instruction word, valid when imem_req && imem_ready.
if_id_write  in  1  downstream write-enable; 1 = consume head entry, 0 = stall/hold.
redirect  in  1  branch/jump taken; single-cycle strobe.
redirect_pc  in  AW  new fetch address, sampled when redirect=1.
if_pc  out  AW  head entry fetch address + 4; 0 when empty.
if_inst  out  32  head entry instruction; 32'h0 (NOP) when empty.
if_valid  out  1  head entry present.
if_flush  out  1  flush strobe to IF/ID register.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, buffer empty (count=0), state=RUN; outputs imem_req=0 during reset, if_valid=0, if_pc=0, if_inst=0, if_flush=0.
- State machine: RUN, DROP.
- RUN: imem_req=1 iff count<2; imem_addr=pc. On imem_req&&imem_ready (no redirect): push {pc+4, imem_rdata} at tail, pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0).
- Handshake: once imem_req=1 is asserted, imem_req and imem_addr stay stable until imem_ready; a request is never withdrawn.
- Pop: if_id_write=1 && count>0 removes head at clock edge. if_id_write=0 holds head and buffer contents unchanged.
- Push and pop in the same cycle: count unchanged, order preserved. With imem_ready tied high and if_id_write=1, throughput is 1 instr/cycle; fetch-to-if_inst latency is 1 cycle.
- Full (count=2): no request issued; a pop re-enables the request in the next cycle.
- Empty: if_valid=0, if_inst=0, if_pc=0; pop is ignored.
- Redirect (any state): if_flush=redirect, combinational, same cycle. At the edge: buffer cleared, pc<=redirect_pc (low 2 bits forced to 0). Redirect takes priority over a simultaneous pop and push.
- Redirect in RUN with request pending and imem_ready=0: go to DROP. Request with the old address stays asserted until imem_ready; that response is discarded; then return to RUN and fetch from the new pc.
- Redirect in RUN with imem_ready=1 in the same cycle: response discarded, stay in RUN, next request uses redirect_pc.
- Redirect in RUN with no pending request: stay in RUN.
- DROP: imem_req=1 with the latched old address. On imem_ready, go to RUN. A further redirect while in DROP updates pc and stays in DROP.
- Reset asserted mid-DROP or mid-request: immediate return to the reset state; the memory side must tolerate the dropped request.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds output ports bubble_cnt (32) and redirect_cnt (32), both reset to 0. bubble_cnt increments on each cycle with if_id_write=1 && count=0. redirect_cnt increments on each redirect cycle. Both counters saturate at 32'hFFFF_FFFF. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then imem_ready=1, if_id_write=1, memory returns addr-as-data -> if_inst sequence 0,4,8,... one per cycle starting the cycle after first req; if_pc = addr+4.
- if_id_write=0 for 5 cycles -> buffer fills to 2, imem_req drops to 0, if_inst/if_pc frozen. Release -> entries drain in order with no loss or duplication.
- imem_ready low 3 cycles per request -> imem_addr stable while pending; if_valid=0 bubbles between instructions.
- redirect to 0x100 while the request at 0x20 is pending (ready=0) -> if_flush=1 same cycle; DROP until ready; 0x20 data discarded; next if_inst is from 0x100 with if_pc=0x104.
- redirect, imem_ready=1 and pop in the same cycle -> buffer empty next cycle; pc=redirect_pc; response dropped.
- pc=0xFFFF_FFFC fetch -> pc wraps to 0x0, if_pc=0x0. Async rst pulse mid-DROP -> imem_req=0 and pc=RESET_PC immediately.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID register through a 2-entry fetch buffer.
// Optional performance counters (bubble_cnt, redirect_cnt) are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
    parameter int             AW       = 32,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [31:0]   imem_rdata,
    input  logic          if_id_write,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] if_pc,
    output logic [31:0]   if_inst,
    output logic          if_valid,
    output logic          if_flush,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]   bubble_cnt,
    output logic [31:0]   redirect_cnt,
`endif
    output logic          dbg_state
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    // Handshake: imem_req/imem_addr are held stable from assertion until imem_ready;
    // a transfer happens on the cycle imem_req && imem_ready, with data in that same cycle.
    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_drop_addr;
    logic          r_imem_req;
    logic [1:0]    r_count;
    logic          r_head;
    logic [AW-1:0] r_buf_pc   [2];
    logic [31:0]   r_buf_inst [2];

    state_t        w_state_n;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_tail;
    logic          w_drop_start;
    logic [1:0]    w_count_n;
    logic          w_req_n;
    logic [AW-1:0] w_pc_plus4;
    logic [AW-1:0] w_redirect_aligned;

    always_comb begin
        w_fire             = r_imem_req & imem_ready;
        w_pop              = if_id_write & (r_count != 2'd0);
        w_push             = (r_state == ST_RUN) & w_fire & ~redirect;
        w_tail             = r_head ^ r_count[0];
        w_pc_plus4         = r_pc + AW'(4);
        w_redirect_aligned = redirect_pc & ~AW'(3);
        // The old request cannot be withdrawn, so its late response must be swallowed.
        w_drop_start       = (r_state == ST_RUN) & redirect & r_imem_req & ~imem_ready;

        w_state_n = r_state;
        case (r_state)
            ST_RUN:  if (w_drop_start) w_state_n = ST_DROP;
            ST_DROP: if (imem_ready)   w_state_n = ST_RUN;
            default: w_state_n = ST_RUN;
        endcase

        if (redirect) begin
            w_count_n = 2'd0;
        end else begin
            w_count_n = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
        w_req_n = (w_state_n == ST_DROP) | (w_count_n != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_drop_addr   <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_count       <= 2'd0;
            r_head        <= 1'b0;
            r_buf_pc[0]   <= '0;
            r_buf_pc[1]   <= '0;
            r_buf_inst[0] <= '0;
            r_buf_inst[1] <= '0;
        end else begin
            r_state    <= w_state_n;
            r_count    <= w_count_n;
            r_imem_req <= w_req_n;
            if (redirect) begin
                r_pc <= w_redirect_aligned;
                if (w_drop_start) begin
                    r_drop_addr <= r_pc;
                end
            end else if (w_push) begin
                r_pc               <= w_pc_plus4;
                r_buf_pc[w_tail]   <= w_pc_plus4;
                r_buf_inst[w_tail] <= imem_rdata;
            end
            if (!redirect && w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = (r_state == ST_DROP) ? r_drop_addr : r_pc;
    assign if_valid  = (r_count != 2'd0);
    assign if_pc     = if_valid ? r_buf_pc[r_head] : '0;
    assign if_inst   = if_valid ? r_buf_inst[r_head] : 32'h0;
    assign if_flush  = redirect;
    assign dbg_state = (r_state == ST_DROP);

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt   <= '0;
            redirect_cnt <= '0;
        end else begin
            if (if_id_write && (r_count == 2'd0) && (bubble_cnt != 32'hFFFF_FFFF)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (redirect && (redirect_cnt != 32'hFFFF_FFFF)) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: randomized and directed stimulus against a queue-based fetch model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        if_id_write = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_flush;
    logic        dbg_state;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_id_write (if_id_write),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_valid    (if_valid),
        .if_flush    (if_flush),
        .dbg_state   (dbg_state)
    );

    // Memory contents are a fixed function of the address so every word is identifiable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction
    assign imem_rdata = mem_word(imem_addr);

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    // Model: fetch addresses waiting in the buffer, oldest first.
    logic [31:0] exp_q[$];
    logic [31:0] m_pc = '0;
    logic        m_drop = 1'b0;
    logic [31:0] m_drop_addr = '0;
    logic        m_started = 1'b0;

    logic        mon_en = 1'b0;
    logic        cur_ready = 1'b0;
    logic        cur_write = 1'b0;
    logic        cur_redir = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_addr = '0;
    logic [31:0] mon_a;

    // Monitor: compares every cycle, consumes the head entry when it is popped.
    always @(negedge clk) begin
        #3;
        if (mon_en) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, pred_req});
            if (pred_req) chk("imem_addr", imem_addr, pred_addr);
            chk("if_flush", {31'b0, if_flush}, {31'b0, cur_redir});
            chk("drop_state", {31'b0, dbg_state}, {31'b0, m_drop});
            if (exp_q.size() == 0) begin
                chk("if_valid_empty", {31'b0, if_valid}, 32'd0);
                chk("if_inst_empty", if_inst, 32'd0);
                chk("if_pc_empty", if_pc, 32'd0);
            end else begin
                mon_a = exp_q[0];
                if (cur_write && !cur_redir) mon_a = exp_q.pop_front();
                chk("if_valid", {31'b0, if_valid}, 32'd1);
                chk("if_inst", if_inst, mem_word(mon_a));
                chk("if_pc", if_pc, mon_a + 32'd4);
            end
        end
    end

    task automatic cycle(input logic rdy, input logic wr, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        #1;
        rst         = 1'b0;
        mon_en      = 1'b1;
        imem_ready  = rdy;
        if_id_write = wr;
        redirect    = rd;
        redirect_pc = rpc;
        cur_ready   = rdy;
        cur_write   = wr;
        cur_redir   = rd;
        // A request is outstanding whenever the buffer has room, or while a stale one drains.
        pred_req    = m_started && (m_drop || (exp_q.size() < 2));
        pred_addr   = m_drop ? m_drop_addr : m_pc;
        #3;
        if (rd) begin
            if (!m_drop) begin
                if (pred_req && !rdy) begin
                    m_drop      = 1'b1;
                    m_drop_addr = m_pc;
                end
            end else if (rdy) begin
                m_drop = 1'b0;
            end
            m_pc = rpc & 32'hFFFF_FFFC;
            exp_q.delete();
        end else if (m_drop) begin
            if (rdy) m_drop = 1'b0;
        end else if (pred_req && rdy) begin
            exp_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        m_started = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        mon_en      = 1'b0;
        rst         = 1'b1;
        imem_ready  = 1'b0;
        if_id_write = 1'b0;
        redirect    = 1'b0;
        #1;
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_if_flush", {31'b0, if_flush}, 32'd0);
        chk("rst_state", {31'b0, dbg_state}, 32'd0);
        exp_q.delete();
        m_pc      = 32'd0;
        m_drop    = 1'b0;
        m_started = 1'b0;
        cur_redir = 1'b0;
    endtask

    int rdy_pct;
    int wr_pct;

    initial begin
        pulse_reset();

        // Streaming at one instruction per cycle.
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Downstream stall fills the buffer, then drains in order.
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Slow memory: three wait cycles per request.
        repeat (4) begin
            repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'd0);
            cycle(1'b1, 1'b1, 1'b0, 32'd0);
        end

        // Redirect to 0x100 while the fetch at 0x20 is waiting.
        pulse_reset();
        for (int i = 0; i < 20 && m_pc != 32'h20; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("reach_0x20", m_pc, 32'h20);
        cycle(1'b0, 1'b1, 1'b1, 32'h100);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect, memory response and pop all in one cycle.
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'h200);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Address wrap past the top of the space, including an unaligned target.
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF6);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Asynchronous reset while dropping a stale response.
        pulse_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h300);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        chk("in_drop_before_rst", {31'b0, m_drop}, 32'd1);
        pulse_reset();
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Randomized phases with varying memory and downstream pressure.
        for (int p = 0; p < 8; p++) begin
            rdy_pct = $urandom_range(20, 100);
            wr_pct  = $urandom_range(20, 100);
            for (int i = 0; i < 400; i++) begin
                logic [31:0] rpc;
                rpc = $urandom;
                if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
                cycle($urandom_range(0, 99) < rdy_pct,
                      $urandom_range(0, 99) < wr_pct,
                      $urandom_range(0, 15) == 0,
                      rpc);
            end
            if ($urandom_range(0, 1) == 1) pulse_reset();
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
